// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares one single-port RAM between three accelerators (FFT, FIR, IIR).
// Each accelerator can request a read burst (get) and a write burst (put);
// the six requesters are arbitrated round-robin and the owner is granted
// a burst of `filesize` words. Get bursts read from offset+count, put bursts
// write to offset+filesize+count (address arithmetic wraps modulo 2^AW).
// A per-requester done bit is raised when a burst completes and remains set
// until that requester drops its request.
//
// Ports
//   clk              clock
//   reset            synchronous, active-low reset
//   offset[AW]       base address of the input buffer (latched at grant)
//   filesize[LW]     words per burst (latched at grant)
//   get_req[3]       read request: bit0 FFT, bit1 FIR, bit2 IIR
//   put_req[3]       write request, same bit order
//   ram_ready        RAM accepts the current access this cycle
//   ram_read_enable  RAM read strobe
//   ram_write_enable RAM write strobe
//   ram_addr[AW]     RAM word address, valid while a strobe is high
//   grant[6]         one-hot owner: [2:0] get FFT/FIR/IIR, [5:3] put
//   read_done[3]     per-accelerator read burst complete
//   write_done[3]    per-accelerator write burst complete
//   busy             burst in progress (XFER or HOLD)

module ram_port_arbiter #(
  parameter int AW = 32,
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] offset,
  input  logic [LW-1:0] filesize,
  input  logic [2:0]    get_req,
  input  logic [2:0]    put_req,
  input  logic          ram_ready,
  output logic          ram_read_enable,
  output logic          ram_write_enable,
  output logic [AW-1:0] ram_addr,
  output logic [5:0]    grant,
  output logic [2:0]    read_done,
  output logic [2:0]    write_done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_reg;
  logic [5:0]    grant_reg;
  logic [5:0]    done_reg;
  logic [2:0]    last_reg;
  logic [AW-1:0] addr_reg;
  logic [LW-1:0] count_reg;
  logic [LW-1:0] len_reg;
  logic          rd_reg;
  logic          wr_reg;
  logic          busy_reg;

  logic [5:0]    req;
  logic [7:0]    elig;
  logic [3:0]    cand;
  logic          pick_valid;
  logic [2:0]    pick_idx;
  logic          pick_is_put;
  logic          owner_req;
  logic          last_word;
  logic          fs_zero;
  logic [5:0]    done_set;

  assign req = {put_req, get_req};

  // A requester that already finished a burst must drop its request
  // before it can compete again. Upper two bits pad the vector to a
  // power of two so a 3-bit index never falls outside it.
  assign elig[7:6] = 2'b00;
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_elig
      assign elig[gi] = req[gi] & ~done_reg[gi];
    end
  endgenerate

  // Round-robin search: scan last+1, last+2, ... (mod 6), first hit wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    cand       = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      cand = {1'b0, last_reg} + 4'(k);
      if (cand >= 4'd6) begin
        cand = cand - 4'd6;
      end
      if (!pick_valid && elig[cand[2:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  assign pick_is_put = (pick_idx >= 3'd3);
  assign owner_req   = |(req & grant_reg);
  assign last_word   = ((count_reg + LW'(1)) == len_reg);
  assign fs_zero     = (filesize == '0);

  // Done bits raised this cycle: either an empty burst selected in IDLE,
  // or the final word of a live burst being accepted.
  always_comb begin
    done_set = 6'd0;
    if (state_reg == IDLE && pick_valid && fs_zero) begin
      done_set = 6'd1 << pick_idx;
    end else if (state_reg == XFER && owner_req && ram_ready && last_word) begin
      done_set = grant_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      grant_reg <= 6'd0;
      done_reg  <= 6'd0;
      last_reg  <= 3'd5;
      addr_reg  <= '0;
      count_reg <= '0;
      len_reg   <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      // A done bit drops one cycle after its request is seen low.
      done_reg <= (done_reg & req) | done_set;

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            last_reg  <= pick_idx;
            len_reg   <= filesize;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            if (fs_zero) begin
              state_reg <= HOLD;
            end else begin
              state_reg <= XFER;
              grant_reg <= 6'd1 << pick_idx;
              rd_reg    <= ~pick_is_put;
              wr_reg    <= pick_is_put;
              // Put bursts land just past the input buffer.
              addr_reg  <= pick_is_put ? (offset + AW'(filesize)) : offset;
            end
          end
        end

        XFER: begin
          if (!owner_req) begin
            // Owner withdrew: abandon the burst without a done bit.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            grant_reg <= 6'd0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
          end else if (ram_ready) begin
            if (last_word) begin
              state_reg <= HOLD;
              grant_reg <= 6'd0;
              rd_reg    <= 1'b0;
              wr_reg    <= 1'b0;
            end else begin
              count_reg <= count_reg + LW'(1);
              addr_reg  <= addr_reg + AW'(1);
            end
          end
        end

        HOLD: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          grant_reg <= 6'd0;
          rd_reg    <= 1'b0;
          wr_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign ram_read_enable  = rd_reg;
  assign ram_write_enable = wr_reg;
  assign ram_addr         = addr_reg;
  assign grant            = grant_reg;
  assign read_done        = done_reg[2:0];
  assign write_done       = done_reg[5:3];
  assign busy             = busy_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//
// Directed scenarios with literal expectations, then a long randomized run.
// A behavioural model (owner index, burst length, words accepted, done
// flags) tracks what the outputs must be and is compared every cycle.

module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] offset;
  logic [31:0] filesize;
  logic [2:0]  get_req;
  logic [2:0]  put_req;
  logic        ram_ready;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [31:0] ram_addr;
  logic [5:0]  grant;
  logic [2:0]  read_done;
  logic [2:0]  write_done;
  logic        busy;

  ram_port_arbiter #(.AW(32), .LW(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .offset           (offset),
    .filesize         (filesize),
    .get_req          (get_req),
    .put_req          (put_req),
    .ram_ready        (ram_ready),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_addr         (ram_addr),
    .grant            (grant),
    .read_done        (read_done),
    .write_done       (write_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_live = 1'b0;   // model meaningful once a reset was seen
  int          m_owner;         // -1 when nobody owns the RAM
  bit          m_hold;          // one-cycle gap after a finished burst
  int          m_last;
  logic [31:0] m_base;
  logic [31:0] m_len;
  logic [31:0] m_cnt;
  logic [5:0]  m_done;

  task automatic model_step();
    logic [5:0] r;
    logic [5:0] el;
    logic [5:0] nd;
    int         idx;
    bit         found;
    if (!reset) begin
      m_live  = 1'b1;
      m_owner = -1;
      m_hold  = 1'b0;
      m_last  = 5;
      m_done  = 6'd0;
      m_cnt   = 32'd0;
      return;
    end
    if (!m_live) return;
    r  = {put_req, get_req};
    el = r & ~m_done;
    nd = m_done & r;
    if (m_hold) begin
      m_hold = 1'b0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        idx = (m_last + k) % 6;
        if (!found && el[idx]) begin
          found  = 1'b1;
          m_last = idx;
          if (filesize == 32'd0) begin
            nd[idx] = 1'b1;
            m_hold  = 1'b1;
          end else begin
            m_owner = idx;
            m_len   = filesize;
            m_cnt   = 32'd0;
            m_base  = offset + ((idx >= 3) ? filesize : 32'd0);
          end
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (ram_ready) begin
      m_cnt = m_cnt + 32'd1;
      if (m_cnt == m_len) begin
        nd[m_owner] = 1'b1;
        m_owner     = -1;
        m_hold      = 1'b1;
      end
    end
    m_done = nd;
  endtask

  task automatic model_compare();
    logic [5:0] eg;
    logic       erd;
    logic       ewr;
    eg  = (m_owner >= 0) ? (6'd1 << m_owner) : 6'd0;
    erd = (m_owner >= 0) && (m_owner < 3);
    ewr = (m_owner >= 3);
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_rd", 32'(ram_read_enable), 32'(erd));
    chk("m_wr", 32'(ram_write_enable), 32'(ewr));
    chk("m_busy", 32'(busy), 32'((m_owner >= 0) || m_hold));
    chk("m_read_done", 32'(read_done), 32'(m_done[2:0]));
    chk("m_write_done", 32'(write_done), 32'(m_done[5:3]));
    if (erd || ewr) chk("m_addr", ram_addr, m_base + m_cnt);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (m_live) model_compare();
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset    = 1'b0;
    get_req  = 3'd0;
    put_req  = 3'd0;
    ram_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] wrap_exp [4];
  logic [4:0]  rdy_seq;
  logic [2:0]  tmp;
  int          acc;

  initial begin
    reset = 1'b0; offset = 32'd0; filesize = 32'd0;
    get_req = 3'd0; put_req = 3'd0; ram_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd", 32'(ram_read_enable), 32'd0);
    chk("rst_wr", 32'(ram_write_enable), 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'({write_done, read_done}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // FFT read burst of 4 words from 0x100.
    get_req = 3'b001; offset = 32'h100; filesize = 32'd4; ram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s1_rd", 32'(ram_read_enable), 32'd1);
      chk("s1_addr", ram_addr, 32'h100 + 32'(i));
      chk("s1_grant", 32'(grant), 32'b000001);
    end
    @(negedge clk);
    chk("s1_rd_off", 32'(ram_read_enable), 32'd0);
    chk("s1_done", 32'(read_done), 32'b001);
    chk("s1_hold_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("s1_idle_busy", 32'(busy), 32'd0);
    chk("s1_done_held", 32'(read_done), 32'b001);
    get_req = 3'b000;
    @(negedge clk);
    chk("s1_done_clr", 32'(read_done), 32'b000);

    // FIR write burst of 3 words; put base is offset+filesize = 0x103.
    do_reset();
    put_req = 3'b010; offset = 32'h100; filesize = 32'd3;
    rdy_seq = 5'b10101;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("s2_wr", 32'(ram_write_enable), 32'd1);
      chk("s2_addr", ram_addr, 32'h103 + 32'(acc));
      chk("s2_grant", 32'(grant), 32'b010000);
      ram_ready = rdy_seq[j];
      acc += int'(rdy_seq[j]);
    end
    @(negedge clk);
    chk("s2_wr_off", 32'(ram_write_enable), 32'd0);
    chk("s2_done", 32'(write_done), 32'b010);
    put_req = 3'b000; ram_ready = 1'b1;
    @(negedge clk);

    // All six requesters, single-word bursts, in index order.
    do_reset();
    get_req = 3'b111; put_req = 3'b111; offset = 32'h200; filesize = 32'd1;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      chk("s3_grant", 32'(grant), 32'(6'd1 << g));
      chk("s3_rd", 32'(ram_read_enable), 32'(g < 3));
      chk("s3_wr", 32'(ram_write_enable), 32'(g >= 3));
      chk("s3_addr", ram_addr, (g < 3) ? 32'h200 : 32'h201);
      @(negedge clk);
      chk("s3_hold_grant", 32'(grant), 32'd0);
      chk("s3_hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("s3_idle_busy", 32'(busy), 32'd0);
    end
    chk("s3_all_done", 32'({write_done, read_done}), 32'b111111);
    get_req = 3'd0; put_req = 3'd0;
    @(negedge clk);

    // Address wrap at the top of the address space.
    do_reset();
    wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0001;
    get_req = 3'b001; offset = 32'hFFFF_FFFE; filesize = 32'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s4_addr", ram_addr, wrap_exp[i]);
    end
    @(negedge clk);
    chk("s4_done", 32'(read_done), 32'b001);
    get_req = 3'd0;
    @(negedge clk);

    // Empty burst: done without any strobe.
    do_reset();
    get_req = 3'b010; filesize = 32'd0;
    @(negedge clk);
    chk("s5_strobes", 32'({ram_write_enable, ram_read_enable}), 32'd0);
    chk("s5_grant", 32'(grant), 32'd0);
    chk("s5_done", 32'(read_done), 32'b010);
    chk("s5_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("s5_idle", 32'(busy), 32'd0);
    get_req = 3'd0;
    @(negedge clk);
    chk("s5_done_clr", 32'(read_done), 32'd0);

    // Reset in the middle of a burst, then restart from word 0.
    do_reset();
    get_req = 3'b001; offset = 32'h300; filesize = 32'd4;
    @(negedge clk);
    chk("s6_addr0", ram_addr, 32'h300);
    @(negedge clk);
    chk("s6_addr1", ram_addr, 32'h301);
    reset = 1'b0;
    @(negedge clk);
    chk("s6_rst_rd", 32'(ram_read_enable), 32'd0);
    chk("s6_rst_grant", 32'(grant), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_addr", ram_addr, 32'd0);
    chk("s6_rst_done", 32'(read_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("s6_restart_rd", 32'(ram_read_enable), 32'd1);
    chk("s6_restart_addr", ram_addr, 32'h300);
    chk("s6_restart_grant", 32'(grant), 32'b000001);

    // Randomized traffic: requests toggle occasionally, RAM stalls,
    // offset/filesize churn every cycle, rare resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) != 0);
      tmp = get_req;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) tmp[b] = ~tmp[b];
      get_req = tmp;
      tmp = put_req;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) tmp[b] = ~tmp[b];
      put_req = tmp;
      offset = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                           : 32'($urandom);
      filesize = 32'($urandom_range(0, 5));
      ram_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
